// File: rtl/periph_pkg.sv
// Shared peripheral definitions: UART receive FSM states and frame constants.
package periph_pkg;

    localparam int UART_DATA_BITS = 8;
    localparam int UART_MIN_DIV   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead circular FIFO with registered count; a pop frees a slot for a same-cycle push.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       din_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    // Output forced to zero when empty so a reset also clears data_o.
    assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop)
            count_d = count_q + (AW+1)'(1);
        else if (do_pop && !do_push)
            count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push)
            mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, sticky error flags and a show-ahead byte FIFO.
module uart_rx_fifo
    import periph_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_W      = 16
) (
    input  logic                          clk_i,
    input  logic                          rst,
    input  logic                          rxd_i,
    input  logic [DIV_W-1:0]              divisor_i,
    input  logic                          rd_i,
    input  logic                          clr_err_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          busy_o,
    output logic                          overrun_o,
    output logic                          frame_err_o
);
    localparam int BW = $clog2(UART_DATA_BITS);

    logic sync1_q, sync1_d;
    logic rxd_s_q, rxd_s_d;
    logic rxd_p_q, rxd_p_d;
    logic overrun_q, overrun_d;
    logic frame_err_q, frame_err_d;

    uart_rx_state_t              state_q;
    logic [DIV_W-1:0]            cnt_q;
    logic [DIV_W-1:0]            div_q;
    logic [BW-1:0]               bit_idx_q;
    logic [UART_DATA_BITS-1:0]   shift_q;

    logic stop_sample, push, fifo_full, fifo_empty;
    logic set_ovr, set_fe;

    assign stop_sample = (state_q == ST_STOP) && (cnt_q == '0);
    assign push        = stop_sample && rxd_s_q && (!fifo_full || rd_i);
    assign set_ovr     = stop_sample && rxd_s_q && fifo_full && !rd_i;
    assign set_fe      = stop_sample && !rxd_s_q;

    always_comb begin
        sync1_d     = rxd_i;
        rxd_s_d     = sync1_q;
        rxd_p_d     = rxd_s_q;
        overrun_d   = set_ovr | (overrun_q & ~clr_err_i);
        frame_err_d = set_fe | (frame_err_q & ~clr_err_i);
    end

    // Synchronizer idles high so reset release never looks like a start edge.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            rxd_s_q     <= 1'b1;
            rxd_p_q     <= 1'b1;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            rxd_s_q     <= rxd_s_d;
            rxd_p_q     <= rxd_p_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            div_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else if (state_q == ST_IDLE) begin
            if (!rxd_s_q && rxd_p_q) begin
                state_q <= ST_START;
                cnt_q   <= divisor_i >> 1;
                div_q   <= divisor_i;
            end
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DIV_W'(1);
        end else begin
            cnt_q <= div_q;
            case (state_q)
                ST_START: begin
                    if (rxd_s_q) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q   <= ST_DATA;
                        bit_idx_q <= '0;
                    end
                end
                ST_DATA: begin
                    shift_q   <= {rxd_s_q, shift_q[UART_DATA_BITS-1:1]};
                    bit_idx_q <= bit_idx_q + BW'(1);
                    if (bit_idx_q == BW'(UART_DATA_BITS - 1))
                        state_q <= ST_STOP;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst     (rst),
        .push_i  (push),
        .din_i   (shift_q),
        .pop_i   (rd_i),
        .dout_o  (data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_o)
    );

    assign valid_o     = !fifo_empty;
    assign busy_o      = (state_q != ST_IDLE);
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench: frames queue expected bytes, a negedge monitor checks every pop.
module tb_uart_rx_fifo;

    logic        clk_i = 1'b0;
    logic        rst = 1'b1;
    logic        rxd_i = 1'b1;
    logic [15:0] divisor_i = 16'd7;
    logic        rd_i = 1'b0;
    logic        clr_err_i = 1'b0;
    logic [7:0]  data_o;
    logic        valid_o;
    logic [3:0]  count_o;
    logic        busy_o, overrun_o, frame_err_o;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(.FIFO_DEPTH(8), .DIV_W(16)) dut (
        .clk_i       (clk_i),
        .rst         (rst),
        .rxd_i       (rxd_i),
        .divisor_i   (divisor_i),
        .rd_i        (rd_i),
        .clr_err_i   (clr_err_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .count_o     (count_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o),
        .frame_err_o (frame_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: each accepted pop must present the oldest expected byte.
    always @(negedge clk_i) begin
        if (!rst && rd_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got %0h expected none", data_o);
            end else begin
                chk("pop_valid", {31'd0, valid_o}, 32'd1);
                chk("pop_data", {24'd0, data_o}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Start bit plus 8 data bits, LSB first; returns 72 negedges after the start.
    task automatic send_head(input logic [7:0] b);
        rxd_i = 1'b0;
        repeat (8) @(negedge clk_i);
        for (int k = 0; k < 8; k++) begin
            rxd_i = b[k];
            repeat (8) @(negedge clk_i);
        end
    endtask

    // Stop bit; optional pop aligned with the stop sample, optional S/S+1 timing check.
    task automatic send_stop(input logic sb, input bit pop_s, input bit tchk, input logic [7:0] b);
        rxd_i = sb;
        repeat (5) @(negedge clk_i);
        @(posedge clk_i); #1 rd_i = pop_s;
        @(negedge clk_i);
        if (tchk) chk("valid_at_S", {31'd0, valid_o}, 32'd0);
        @(posedge clk_i); #1 rd_i = 1'b0;
        @(negedge clk_i);
        if (tchk) begin
            chk("valid_at_S1", {31'd0, valid_o}, 32'd1);
            chk("data_at_S1", {24'd0, data_o}, {24'd0, b});
            chk("count_at_S1", {28'd0, count_o}, 32'd1);
        end
        rxd_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit expect_store);
        if (expect_store) exp_q.push_back(b);
        send_head(b);
        send_stop(1'b1, 1'b0, 1'b0, b);
    endtask

    task automatic pop;
        @(posedge clk_i); #1 rd_i = 1'b1;
        @(posedge clk_i); #1 rd_i = 1'b0;
    endtask

    task automatic clear_err;
        @(posedge clk_i); #1 clr_err_i = 1'b1;
        @(posedge clk_i); #1 clr_err_i = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"}, {24'd0, data_o}, 32'd0);
        chk({tag, "_valid"}, {31'd0, valid_o}, 32'd0);
        chk({tag, "_count"}, {28'd0, count_o}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
        chk({tag, "_ovr"}, {31'd0, overrun_o}, 32'd0);
        chk({tag, "_fe"}, {31'd0, frame_err_o}, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        chk_reset_vals("rst");
        rst = 1'b0;
        repeat (4) @(negedge clk_i);

        // Single byte with exact S+1 visibility, then pop.
        exp_q.push_back(8'h55);
        send_head(8'h55);
        send_stop(1'b1, 1'b0, 1'b1, 8'h55);
        chk("single_ovr", {31'd0, overrun_o}, 32'd0);
        chk("single_fe", {31'd0, frame_err_o}, 32'd0);
        pop();
        @(negedge clk_i);
        chk("single_count_after_pop", {28'd0, count_o}, 32'd0);
        chk("single_valid_after_pop", {31'd0, valid_o}, 32'd0);

        // Glitch: 3 clocks low looks like a start edge but fails the start sample.
        rxd_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rxd_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("glitch_busy_mid", {31'd0, busy_o}, 32'd1);
        repeat (20) @(negedge clk_i);
        chk("glitch_busy_end", {31'd0, busy_o}, 32'd0);
        chk("glitch_count", {28'd0, count_o}, 32'd0);
        chk("glitch_fe", {31'd0, frame_err_o}, 32'd0);
        chk("glitch_ovr", {31'd0, overrun_o}, 32'd0);

        // Framing error.
        send_head(8'hA3);
        send_stop(1'b0, 1'b0, 1'b0, 8'hA3);
        chk("fe_flag", {31'd0, frame_err_o}, 32'd1);
        chk("fe_count", {28'd0, count_o}, 32'd0);
        clear_err();
        @(negedge clk_i);
        chk("fe_cleared", {31'd0, frame_err_o}, 32'd0);

        // Overrun: nine back-to-back bytes, last one dropped.
        for (int i = 0; i < 9; i++) send_byte(8'(i), i < 8);
        chk("ovr_count", {28'd0, count_o}, 32'd8);
        chk("ovr_head", {24'd0, data_o}, 32'h00);
        chk("ovr_flag", {31'd0, overrun_o}, 32'd1);
        chk("ovr_fe", {31'd0, frame_err_o}, 32'd0);
        for (int i = 0; i < 8; i++) pop();
        @(negedge clk_i);
        chk("ovr_drained", {28'd0, count_o}, 32'd0);
        clear_err();
        @(negedge clk_i);
        chk("ovr_cleared", {31'd0, overrun_o}, 32'd0);

        // Full boundary: pop coincides with the ninth stop sample.
        for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i), 1'b1);
        chk("full_count", {28'd0, count_o}, 32'd8);
        exp_q.push_back(8'h18);
        send_head(8'h18);
        send_stop(1'b1, 1'b1, 1'b0, 8'h18);
        chk("full_count_kept", {28'd0, count_o}, 32'd8);
        chk("full_no_ovr", {31'd0, overrun_o}, 32'd0);
        for (int i = 0; i < 8; i++) pop();
        @(negedge clk_i);
        chk("full_drained", {28'd0, count_o}, 32'd0);

        // Reset during data bit 4 with two bytes queued.
        send_byte(8'h31, 1'b0);
        send_byte(8'h32, 1'b0);
        chk("pre_rst_count", {28'd0, count_o}, 32'd2);
        rxd_i = 1'b0;
        repeat (8) @(negedge clk_i);
        for (int k = 0; k < 4; k++) begin
            rxd_i = k[0];
            repeat (8) @(negedge clk_i);
        end
        rxd_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("pre_rst_busy", {31'd0, busy_o}, 32'd1);
        rst = 1'b1;
        rxd_i = 1'b1;
        @(negedge clk_i);
        chk_reset_vals("midrst");
        repeat (2) @(negedge clk_i);
        rst = 1'b0;
        repeat (6) @(negedge clk_i);
        chk("post_rst_busy", {31'd0, busy_o}, 32'd0);
        send_byte(8'hC3, 1'b1);
        chk("post_rst_count", {28'd0, count_o}, 32'd1);
        chk("post_rst_data", {24'd0, data_o}, 32'hC3);
        pop();
        @(negedge clk_i);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        chk("final_valid", {31'd0, valid_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive front end for the 65RV32 CPU macro's UART. It takes the already pin-muxed RXD line at pad level, recovers 8N1 frames with a mid-bit sampling state machine, and buffers received bytes in a small show-ahead FIFO. The CPU-side bus logic drains the FIFO through a pop strobe.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: FIFO entries; power of two, 2..32.
- `DIV_W`, default 16: width of the bit-period divisor.

Ports:
- `clk_i`  in  1: sole clock (PH0IN domain).
- `rst`  in  1: reset; asynchronous, active-high.
- `rxd_i`  in  1: raw serial input, asynchronous to `clk_i`, idle high.
- `divisor_i`  in  DIV_W: bit period minus one, in clocks. Legal range is 3 or greater.
- `rd_i`  in  1: pop strobe; one byte per asserted cycle.
- `clr_err_i`  in  1: clears the sticky error flags.
- `data_o`  out  8: head-of-FIFO byte (show-ahead).
- `valid_o`  out  1: FIFO not empty.
- `count_o`  out  $clog2(FIFO_DEPTH)+1: number of entries.
- `busy_o`  out  1: the FSM is not in IDLE.
- `overrun_o`  out  1: sticky; a byte was dropped because the FIFO was full.
- `frame_err_o`  out  1: sticky; a stop bit was sampled as 0.

## Operation
- **Synchronizer.** `rxd_i` passes through a 2-flop synchronizer to give `rxd_s`. A third flop, `rxd_p`, holds the previous value of `rxd_s`. All three flops reset to 1.
- **Divisor latch.** `div_q` captures `divisor_i` on the start edge. Changing `divisor_i` mid-frame has no effect on the current frame.
- **Bit counter.** `cnt` (DIV_W bits) decrements by one every cycle while the FSM is not in IDLE. A sample is taken on the cycle where `cnt==0`, and `cnt` then reloads with `div_q`.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE → START when `rxd_s==0 && rxd_p==1`. On this transition, `cnt <= divisor_i>>1`.
  - START sample:
    - `rxd_s==1`: false start, return to IDLE with no flags set.
    - `rxd_s==0`: go to DATA with bit index 0.
  - DATA: shift the sampled bit in LSB-first. After bit index 7, go to STOP.
  - STOP sample, then return to IDLE on the next cycle:
    - `rxd_s==1` and the FIFO has room (or `rd_i` is asserted the same cycle): push the byte.
    - `rxd_s==1` and the FIFO is full with no pop: drop the byte and set `overrun_o`.
    - `rxd_s==0`: drop the byte and set `frame_err_o`. The FIFO is unchanged.
- **FIFO.** Circular buffer with read/write pointers; `count_o` is held as a register.
  - Pop while empty is ignored.
  - Push and pop in the same cycle leave the count unchanged; this includes the full case, where the push is accepted.
- **Error flags.** `clr_err_i` clears both sticky flags. If an error is set in the same cycle as `clr_err_i`, the set wins.
- **Reset values.**
  - `data_o` = 0, `valid_o` = 0, `count_o` = 0, `busy_o` = 0, `overrun_o` = 0, `frame_err_o` = 0.
  - FSM in IDLE, both FIFO pointers at 0.
  - Reset asserted mid-frame discards the partial byte and empties the FIFO. No spurious start follows reset release, because the synchronizer flops reset to 1.

## Timing
Let E be the cycle in which IDLE detects the falling edge, and let D be the latched divisor.
- START sample: cycle E+1+(D>>1).
- Data bit k sample: cycle E+1+(D>>1)+(k+1)(D+1).
- STOP sample: cycle S = E+1+(D>>1)+9(D+1).
- `valid_o`, `count_o` and `data_o` reflect the pushed byte in cycle S+1.
- `busy_o` is high from E+1 through S.
- The FSM is in IDLE at S+1, so a start edge arriving immediately after the stop bit is detected; back-to-back frames are supported.
- Pop: `data_o` and `count_o` update one cycle after the `rd_i` cycle.
- Pad-to-edge latency: a falling `rxd_i` edge is visible as E two or three clock edges later.

## Structure
- A shared package `periph_pkg` holds:
  - the FSM state enum `uart_rx_state_t`;
  - constant `UART_DATA_BITS = 8`;
  - the minimum-divisor constant `UART_MIN_DIV = 3`.
- One sub-module, `sync_fifo`, is parameterised by width and depth and provides push, pop, full, empty and count. The FSM, synchronizer and error flags stay at top level.

## Test plan
All scenarios use D=7 (8 clocks per bit), FIFO_DEPTH=8, and a bench model driving 8N1 frames.
- **Single byte.** Send 0x55 → `valid_o`=1 at S+1, `data_o`=0x55, `count_o`=1, no flags set. Pulse `rd_i` → `count_o`=0 and `valid_o`=0 on the next cycle.
- **Glitch rejection.** Hold `rxd_i` low for 3 clocks, then high → FSM returns to IDLE, nothing pushed, no flags set.
- **Framing error.** Send 0xA3 with stop bit = 0 → `frame_err_o`=1, `count_o`=0. Assert `clr_err_i` → flag clears.
- **Overrun.** Send 9 bytes 0x00..0x08 with no pops → `count_o`=8, `data_o`=0x00, `overrun_o`=1, byte 0x08 lost. Pop 8 times → bytes 0x00..0x07 come out in order.
- **Full boundary.** With the FIFO full, pulse `rd_i` in the same cycle as the 9th byte's STOP sample → byte accepted, `count_o` stays 8, `overrun_o`=0.
- **Reset mid-frame.** Assert `rst` during data bit 4 of a frame, with 2 bytes already queued → all outputs return to reset values. A clean 0xC3 frame sent afterwards is received correctly.
